mux81_scan_ctrl: RTL and testbench

Channel-scan sequencer that sits directly upstream of the 8:1 multiplexer `mux81`. It drives the mux select lines `s0`/`s1`/`s2` through the enabled channels in ascending order. Each selection is held for a programmable dwell time, after which the mux output `y` is captured. The block reports each captured bit, and once per frame it delivers an 8-bit snapshot of all enabled channels.

---
 rtl/mux81_scan_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mux81_scan_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux81_scan_ctrl.sv
// mux81_scan_ctrl: channel-scan sequencer for the 8:1 multiplexer mux81.
// Steps the mux selects through the enabled channels in ascending order.
// Each selection is held for DWELL cycles, then the mux output y is captured.
// Every captured bit is reported, and one 8-bit frame is delivered per scan.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request one scan (sampled only when idle)
//   stop                abort the scan in progress
//   continuous          rescan after each frame (sampled at frame end)
//   ch_en[7:0]          channel enable mask, latched at start / frame wrap
//   y                   mux81 output
//   s0, s1, s2          mux selects, {s2,s1,s0} = channel index
//   busy                scan in progress
//   smp_valid           one-cycle pulse: smp_ch / smp_bit hold a new capture
//   smp_ch[2:0]         channel of the captured bit
//   smp_bit             captured value of y
//   frame[7:0]          last completed frame, disabled channels read 0
//   frame_done          one-cycle pulse: frame has just been updated
module mux81_scan_ctrl #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       continuous,
  input  logic [7:0] ch_en,
  input  logic       y,
  output logic       s0,
  output logic       s1,
  output logic       s2,
  output logic       busy,
  output logic       smp_valid,
  output logic [2:0] smp_ch,
  output logic       smp_bit,
  output logic [7:0] frame,
  output logic       frame_done
);

  typedef enum logic {StIdle, StDwell} state_e;

  localparam logic [7:0] DwellLast = 8'(DWELL - 1);

  // Index of the lowest set bit of m (0 when m is empty).
  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // {found, index} of the lowest set bit of m strictly above cur.
  function automatic logic [3:0] next_bit(input logic [7:0] m, input logic [2:0] cur);
    logic [3:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i > int'(cur))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] ch_q, ch_d;
  logic [7:0] en_q, en_d;
  logic [7:0] work_q, work_d;
  logic [7:0] frame_q, frame_d;
  logic       smp_valid_q, smp_valid_d;
  logic [2:0] smp_ch_q, smp_ch_d;
  logic       smp_bit_q, smp_bit_d;
  logic       frame_done_q, frame_done_d;

  logic [7:0] captured;
  logic [3:0] nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      ch_q         <= '0;
      en_q         <= '0;
      work_q       <= '0;
      frame_q      <= '0;
      smp_valid_q  <= 1'b0;
      smp_ch_q     <= '0;
      smp_bit_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ch_q         <= ch_d;
      en_q         <= en_d;
      work_q       <= work_d;
      frame_q      <= frame_d;
      smp_valid_q  <= smp_valid_d;
      smp_ch_q     <= smp_ch_d;
      smp_bit_q    <= smp_bit_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ch_d         = ch_q;
    en_d         = en_q;
    work_d       = work_q;
    frame_d      = frame_q;
    smp_valid_d  = 1'b0;
    smp_ch_d     = smp_ch_q;
    smp_bit_d    = smp_bit_q;
    frame_done_d = 1'b0;

    // Working frame with the current channel's bit replaced by y.
    captured       = work_q;
    captured[ch_q] = y;
    nxt            = next_bit(en_q, ch_q);

    case (state_q)
      StIdle: begin
        if (start && (ch_en != '0)) begin
          en_d    = ch_en;
          work_d  = '0;
          ch_d    = lowest_bit(ch_en);
          cnt_d   = '0;
          state_d = StDwell;
        end
      end
      StDwell: begin
        // stop wins over a capture falling in the same cycle
        if (stop) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DwellLast) begin
          cnt_d       = '0;
          smp_valid_d = 1'b1;
          smp_ch_d    = ch_q;
          smp_bit_d   = y;
          if (nxt[3]) begin
            ch_d   = nxt[2:0];
            work_d = captured;
          end else begin
            frame_d      = captured;
            frame_done_d = 1'b1;
            work_d       = '0;
            if (continuous) begin
              en_d = ch_en;
              if (ch_en != '0) begin
                ch_d = lowest_bit(ch_en);
              end else begin
                state_d = StIdle;
              end
            end else begin
              state_d = StIdle;
            end
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    {s2, s1, s0} = ch_q;
    busy         = (state_q == StDwell);
    smp_valid    = smp_valid_q;
    smp_ch       = smp_ch_q;
    smp_bit      = smp_bit_q;
    frame        = frame_q;
    frame_done   = frame_done_q;
  end

endmodule

// File: tb/tb_mux81_scan_ctrl.sv
module tb_mux81_scan_ctrl;

  localparam int unsigned DW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, continuous = 1'b0;
  logic [7:0] ch_en = '0;
  logic [7:0] imux = '0;
  logic       y;
  logic       s0, s1, s2, busy, smp_valid, smp_bit, frame_done;
  logic [2:0] smp_ch;
  logic [7:0] frame;

  // second instance exercising the minimum dwell
  logic       start1 = 1'b0, stop1 = 1'b0, cont1 = 1'b0;
  logic [7:0] ch_en1 = '0;
  logic [7:0] imux1 = '0;
  logic       y1;
  logic       s0_1, s1_1, s2_1, busy1, smp_valid1, smp_bit1, frame_done1;
  logic [2:0] smp_ch1;
  logic [7:0] frame1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign y  = imux[{s2, s1, s0}];
  assign y1 = imux1[{s2_1, s1_1, s0_1}];

  mux81_scan_ctrl #(.DWELL(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .continuous(continuous),
    .ch_en(ch_en), .y(y), .s0(s0), .s1(s1), .s2(s2), .busy(busy),
    .smp_valid(smp_valid), .smp_ch(smp_ch), .smp_bit(smp_bit), .frame(frame),
    .frame_done(frame_done)
  );

  mux81_scan_ctrl #(.DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1), .continuous(cont1),
    .ch_en(ch_en1), .y(y1), .s0(s0_1), .s1(s1_1), .s2(s2_1), .busy(busy1),
    .smp_valid(smp_valid1), .smp_ch(smp_ch1), .smp_bit(smp_bit1), .frame(frame1),
    .frame_done(frame_done1)
  );

  // Reference model: a scan is the ordered list of enabled channels, each
  // owning DW consecutive cycles; t is the elapsed cycles on the current one.
  bit         m_act;
  int         m_list[$];
  int         m_pos;
  int         m_t;
  logic [7:0] m_acc;
  logic [2:0] m_sel;
  logic       m_pv, m_pd, m_pbit;
  logic [2:0] m_pch;
  logic [7:0] m_frame;

  task automatic m_reset();
    m_act = 0; m_list.delete(); m_pos = 0; m_t = 0; m_acc = '0; m_sel = '0;
    m_pv = 0; m_pd = 0; m_pbit = 0; m_pch = '0; m_frame = '0;
  endtask

  task automatic m_begin(input logic [7:0] en);
    m_list.delete();
    for (int k = 0; k < 8; k++) if (en[k]) m_list.push_back(k);
    m_pos = 0; m_t = 0; m_acc = '0; m_sel = 3'(m_list[0]);
  endtask

  task automatic model_step();
    logic y_now;
    y_now = imux[m_sel];
    m_pv = 0; m_pd = 0;
    if (!m_act) begin
      if (start && ch_en != '0) begin m_act = 1; m_begin(ch_en); end
    end else if (stop) begin
      m_act = 0;
    end else begin
      m_t++;
      if (m_t == int'(DW)) begin
        m_t = 0; m_pv = 1; m_pch = m_sel; m_pbit = y_now;
        if (y_now) m_acc[m_sel] = 1'b1;
        m_pos++;
        if (m_pos == m_list.size()) begin
          m_frame = m_acc; m_pd = 1;
          if (continuous && ch_en != '0) m_begin(ch_en);
          else m_act = 0;
        end else begin
          m_sel = 3'(m_list[m_pos]);
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("sel", 8'({s2, s1, s0}), 8'(m_sel));
    check("busy", 8'(busy), 8'(m_act));
    check("smp_valid", 8'(smp_valid), 8'(m_pv));
    check("frame_done", 8'(frame_done), 8'(m_pd));
    check("frame", frame, m_frame);
    if (m_pv) begin
      check("smp_ch", 8'(smp_ch), 8'(m_pch));
      check("smp_bit", 8'(smp_bit), 8'(m_pbit));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sel"}, 8'({s2, s1, s0}), 8'h00);
    check({tag, "_busy"}, 8'(busy), 8'h00);
    check({tag, "_valid"}, 8'(smp_valid), 8'h00);
    check({tag, "_ch"}, 8'(smp_ch), 8'h00);
    check({tag, "_bit"}, 8'(smp_bit), 8'h00);
    check({tag, "_frame"}, frame, 8'h00);
    check({tag, "_fdone"}, 8'(frame_done), 8'h00);
  endtask

  initial begin
    m_reset();
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic scan: i0=1, i2=0, i7=1
    ch_en = 8'b1000_0101;
    imux  = 8'b1000_0001;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 2; c <= 13; c++) begin
      cycle();
      if (c == 5) check("basic_c5_ch", 8'(smp_ch), 8'h00);
      if (c == 9) check("basic_c9_sel", 8'({s2, s1, s0}), 8'h07);
    end
    check("basic_c13_fdone", 8'(frame_done), 8'h01);
    check("basic_c13_frame", frame, 8'h81);
    check("basic_c13_busy", 8'(busy), 8'h00);

    // start with an empty mask is ignored
    ch_en = 8'h00;
    start = 1'b1;
    for (int c = 0; c < 3; c++) cycle();
    start = 1'b0;
    check("empty_start_busy", 8'(busy), 8'h00);

    // start pulses while busy leave the timing untouched
    ch_en = 8'b1000_0101;
    start = 1'b1;
    cycle();
    for (int c = 2; c <= 14; c++) begin
      start = (c == 3 || c == 8) ? 1'b1 : 1'b0;
      cycle();
    end
    start = 1'b0;

    // abort at cycle 6
    imux  = 8'b1000_0101;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 2; c <= 6; c++) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check("abort_busy", 8'(busy), 8'h00);
    check("abort_frame", frame, 8'h81);
    for (int c = 0; c < 8; c++) cycle();

    // continuous wrap, y high only on channel 3
    ch_en = 8'hFF;
    imux = 8'h08;
    continuous = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 2; c <= 70; c++) begin
      cycle();
      if (c == 33 || c == 65) begin
        check("cont_fdone", 8'(frame_done), 8'h01);
        check("cont_frame", frame, 8'h08);
        check("cont_busy", 8'(busy), 8'h01);
      end
    end
    ch_en = 8'h00;
    for (int c = 0; c < 30; c++) cycle();
    check("cont_drop_busy", 8'(busy), 8'h00);
    continuous = 1'b0;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(7) == 0);
      stop  = ($urandom_range(59) == 0);
      if ($urandom_range(49) == 0) ch_en = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(79) == 0) continuous = ~continuous;
      if ($urandom_range(99) == 0) imux = 8'($urandom);
      cycle();
    end
    start = 1'b0; continuous = 1'b0;
    stop = 1'b1;
    cycle();
    stop = 1'b0;

    // asynchronous reset in the middle of a scan
    ch_en = 8'b1000_0101;
    imux  = 8'b1000_0001;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 2; c <= 10; c++) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    m_reset();
    #1;
    rst_n = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int c = 2; c <= 13; c++) cycle();
    check("rst_scan_frame", frame, 8'h81);

    // minimum dwell on the second instance: i1=0, i4=1
    ch_en1 = 8'b0001_0010;
    imux1  = 8'b0001_0000;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("dw1_c1_sel", 8'({s2_1, s1_1, s0_1}), 8'h01);
    check("dw1_c1_busy", 8'(busy1), 8'h01);
    check("dw1_c1_valid", 8'(smp_valid1), 8'h00);
    @(posedge clk); #1;
    check("dw1_c2_sel", 8'({s2_1, s1_1, s0_1}), 8'h04);
    check("dw1_c2_valid", 8'(smp_valid1), 8'h01);
    check("dw1_c2_ch", 8'(smp_ch1), 8'h01);
    check("dw1_c2_bit", 8'(smp_bit1), 8'h00);
    @(posedge clk); #1;
    check("dw1_c3_valid", 8'(smp_valid1), 8'h01);
    check("dw1_c3_ch", 8'(smp_ch1), 8'h04);
    check("dw1_c3_bit", 8'(smp_bit1), 8'h01);
    check("dw1_c3_fdone", 8'(frame_done1), 8'h01);
    check("dw1_c3_frame", frame1, 8'h10);
    check("dw1_c3_busy", 8'(busy1), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
